// File: rtl/pkt_merge_pkg.sv
// Shared constants, state type and beat-folding helper for the merger drain checker.
package pkt_merge_pkg;

  localparam int DATA_W  = 153;
  localparam int SIG_W   = 32;
  localparam int SOP_BIT = 152;
  localparam int EOP_BIT = 151;

  localparam logic [SIG_W-1:0] SIG_SEED   = 32'hFFFF_FFFF;
  localparam logic [SIG_W-1:0] POLY       = 32'h04C1_1DB7;
  localparam logic [15:0]      LFSR_SEED  = 16'hACE1;

  localparam int FOLD_WORDS = (DATA_W + SIG_W - 1) / SIG_W;

  typedef enum logic {
    OUT_PKT = 1'b0,
    IN_PKT  = 1'b1
  } drain_state_t;

  // Zero-pad the beat to whole signature words and XOR the words together.
  function automatic logic [SIG_W-1:0] fold_beat(input logic [DATA_W-1:0] beat);
    logic [FOLD_WORDS*SIG_W-1:0] padded;
    logic [SIG_W-1:0]            acc;
    padded = '0;
    padded[DATA_W-1:0] = beat;
    acc = '0;
    for (int w = 0; w < FOLD_WORDS; w++) begin
      acc = acc ^ padded[w*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/pkt_sig_misr.sv
// Multiple-input signature register: compresses every popped beat into a CRC-style signature.
module pkt_sig_misr
  import pkt_merge_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  // Shift with polynomial feedback and fold in the beat on every pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig <= SIG_SEED;
    end else if (load_en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ fold_beat(data) ^ (sig[SIG_W-1] ? POLY : '0);
    end
  end

endmodule

// File: rtl/pkt_drain_checker.sv
// Drains the merger output port with LFSR-paced backpressure, checks SOP/EOP framing,
// counts complete packets and keeps a MISR signature of every beat consumed.
//
// state   | meaning
// OUT_PKT | between packets, next beat must carry sop
// IN_PKT  | inside a packet, beat_cnt beats taken so far
module pkt_drain_checker #(
  parameter int DATA_W     = pkt_merge_pkg::DATA_W,
  parameter int SIG_W      = pkt_merge_pkg::SIG_W,
  parameter int MAX_BEATS  = 64,
  parameter int STALL_EN   = 1,
  parameter int STALL_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rdy_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              en_out,
  output logic [SIG_W-1:0]  sig_out,
  output logic [15:0]       pkt_count,
  output logic              framing_err,
  output logic              busy
);

  import pkt_merge_pkg::*;

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);

  drain_state_t     state;
  logic [CNT_W-1:0] beat_cnt;
  logic [15:0]      lfsr;
  logic             stall;
  logic             sop;
  logic             eop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign stall  = (STALL_EN != 0) && (lfsr[STALL_BITS-1:0] == '0);
  // Gated by reset so the merger never sees a pop strobe while we are held in reset.
  assign en_out = reset & rdy_in & enable & ~stall;
  assign sop    = data_in[SOP_BIT];
  assign eop    = data_in[EOP_BIT];

  // Backpressure pacing LFSR, frozen together with everything else when enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (enable) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Framing FSM: tracks packet boundaries, counts good packets, latches any framing error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= OUT_PKT;
      beat_cnt    <= '0;
      pkt_count   <= '0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else if (en_out) begin
      unique case (state)
        OUT_PKT: begin
          if (sop && eop) begin
            pkt_count <= sat_inc(pkt_count);
          end else if (sop) begin
            state    <= IN_PKT;
            busy     <= 1'b1;
            beat_cnt <= ONE_BEAT;
          end else begin
            framing_err <= 1'b1;
          end
        end
        IN_PKT: begin
          if (sop) begin
            // Unterminated packet is abandoned; this beat opens the next one.
            framing_err <= 1'b1;
            if (eop) begin
              pkt_count <= sat_inc(pkt_count);
              state     <= OUT_PKT;
              busy      <= 1'b0;
              beat_cnt  <= '0;
            end else begin
              beat_cnt <= ONE_BEAT;
            end
          end else if (eop) begin
            pkt_count <= sat_inc(pkt_count);
            state     <= OUT_PKT;
            busy      <= 1'b0;
            beat_cnt  <= '0;
          end else if (beat_cnt == LAST_BEAT) begin
            framing_err <= 1'b1;
            state       <= OUT_PKT;
            busy        <= 1'b0;
            beat_cnt    <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  pkt_sig_misr u_misr (
    .clk     (clk),
    .reset   (reset),
    .load_en (en_out),
    .data    (data_in),
    .sig     (sig_out)
  );

endmodule
